// File: rtl/bmp180_dbg_view.sv
// Board-level debug viewer for the BMP180 controller: debounced command key,
// paged 8-bit view of N_CH channel values, auto-scan, freeze and status LEDs.
module bmp180_dbg_view #(
    parameter int FPGA_CLK = 50_000_000,
    parameter int N_CH     = 2,
    parameter int VAL_W    = 19,
    parameter int DEB_MS   = 10,
    parameter int SCAN_MS  = 1000,
    localparam int PPC     = (VAL_W + 7) / 8,
    localparam int NPG     = N_CH * PPC,
    localparam int SEL_W   = (NPG > 1) ? $clog2(NPG) : 1
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  I_KEY_CMD,
    input  logic [3:0]            I_SW_CMD,
    input  logic [SEL_W-1:0]      I_SW_SEL,
    input  logic                  I_SW_SCAN,
    input  logic                  I_SW_FREEZE,
    input  logic [N_CH*VAL_W-1:0] I_VALUES,
    input  logic                  I_ACK,
    input  logic                  I_ERR,
    output logic [3:0]            O_COMM,
    output logic                  O_COMM_VLD,
    output logic [SEL_W-1:0]      O_PAGE,
    output logic [9:0]            O_LEDR
);
    localparam int DEB_CYC  = FPGA_CLK / 1000 * DEB_MS;
    localparam int SCAN_CYC = FPGA_CLK / 1000 * SCAN_MS;
    localparam int DEB_W    = $clog2(DEB_CYC + 1);
    localparam int SCAN_W   = $clog2(SCAN_CYC + 1);
    localparam int NSLOT    = 2 ** SEL_W;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
    localparam logic [SEL_W-1:0]  PG_LAST   = SEL_W'(NPG - 1);
    localparam logic [SEL_W:0]    NPG_X     = (SEL_W + 1)'(NPG);

    logic [1:0]        r_sync;
    logic              r_pressed;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic              r_comm_vld;
    logic [3:0]        r_comm;
    logic [SEL_W-1:0]  r_page;
    logic [SCAN_W-1:0] r_dwell;
    logic              r_scan_d;
    logic [7:0]        r_data;
    logic              r_ack;
    logic              r_err;

    logic              w_key_prs;
    logic              w_deb_flip;
    logic              w_press;
    logic [SEL_W-1:0]  w_page_nxt;
    logic [SCAN_W-1:0] w_dwell_nxt;
    logic [N_CH-1:0][PPC*8-1:0] w_ext;
    logic [NSLOT-1:0][7:0]      w_bytes;

    // Key is active-low; track the debounced level as "pressed"
    assign w_key_prs  = ~r_sync[1];
    assign w_deb_flip = (w_key_prs != r_pressed) && (r_deb_cnt == DEB_LAST);
    assign w_press    = w_deb_flip & ~r_pressed;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync     <= 2'b11;
            r_pressed  <= 1'b0;
            r_deb_cnt  <= '0;
            r_comm_vld <= 1'b0;
            r_comm     <= 4'h0;
        end else begin
            r_sync <= {r_sync[0], I_KEY_CMD};
            if (w_key_prs == r_pressed || w_deb_flip)
                r_deb_cnt <= '0;
            else
                r_deb_cnt <= r_deb_cnt + 1'b1;
            if (w_deb_flip)
                r_pressed <= ~r_pressed;
            r_comm_vld <= w_press;
            r_comm     <= w_press ? I_SW_CMD : 4'h0;
        end
    end

    // Byte table indexed by page; slots beyond NPG read as zero
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_ext[c] = (PPC*8)'(I_VALUES[c*VAL_W +: VAL_W]);
    end
    for (genvar p = 0; p < NSLOT; p++) begin : g_pg
        if (p < NPG) begin : g_on
            assign w_bytes[p] = w_ext[p / PPC][(PPC - p % PPC)*8-1 -: 8];
        end else begin : g_off
            assign w_bytes[p] = 8'h00;
        end
    end

    always_comb begin
        w_page_nxt  = r_page;
        w_dwell_nxt = r_dwell;
        if (!I_SW_FREEZE) begin
            if (!I_SW_SCAN) begin
                w_page_nxt  = I_SW_SEL;
                w_dwell_nxt = '0;
            end else if (!r_scan_d) begin
                w_page_nxt  = ({1'b0, r_page} < NPG_X) ? r_page : '0;
                w_dwell_nxt = '0;
            end else if (r_dwell == SCAN_LAST) begin
                w_dwell_nxt = '0;
                w_page_nxt  = (r_page == PG_LAST) ? '0 : r_page + 1'b1;
            end else begin
                w_dwell_nxt = r_dwell + 1'b1;
            end
        end
    end

    // Scan-entry detection is held while frozen so it fires on unfreeze
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_page   <= '0;
            r_dwell  <= '0;
            r_scan_d <= 1'b0;
            r_data   <= 8'h00;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_page  <= w_page_nxt;
            r_dwell <= w_dwell_nxt;
            if (!I_SW_FREEZE) begin
                r_scan_d <= I_SW_SCAN;
                r_data   <= w_bytes[w_page_nxt];
            end
            r_ack <= I_ACK;
            r_err <= I_ERR | (r_err & ~r_comm_vld);
        end
    end

    assign O_COMM     = r_comm;
    assign O_COMM_VLD = r_comm_vld;
    assign O_PAGE     = r_page;
    assign O_LEDR     = {r_err, r_ack, r_data};
endmodule

// File: tb/tb_bmp180_dbg_view.sv
// Directed bench for bmp180_dbg_view: debounce, paging, scan/freeze, sticky
// error, mid-run reset, and a 3-channel 16-bit configuration.
module tb_bmp180_dbg_view;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key = 1'b1;
    logic [3:0]  cmd = 4'h0;
    logic [2:0]  sel = 3'd0, sel3 = 3'd0;
    logic        scan = 1'b0, frz = 1'b0, ack = 1'b0, err = 1'b0;
    logic [37:0] vals;
    logic [47:0] vals3;
    logic [3:0]  comm, comm3;
    logic        vld, vld3;
    logic [2:0]  page, page3;
    logic [9:0]  ledr, ledr3;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] exp2 [8] = '{8'h00, 8'hAB, 8'hCD, 8'h05, 8'h12, 8'h34, 8'h00, 8'h00};
    logic [7:0] exp6 [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00, 8'h00};

    always #5 clk = ~clk;

    bmp180_dbg_view #(.FPGA_CLK(4000), .N_CH(2), .VAL_W(19), .DEB_MS(1), .SCAN_MS(2)) u_dut (
        .CLK(clk), .RST_n(rst_n), .I_KEY_CMD(key), .I_SW_CMD(cmd), .I_SW_SEL(sel),
        .I_SW_SCAN(scan), .I_SW_FREEZE(frz), .I_VALUES(vals), .I_ACK(ack), .I_ERR(err),
        .O_COMM(comm), .O_COMM_VLD(vld), .O_PAGE(page), .O_LEDR(ledr));

    bmp180_dbg_view #(.FPGA_CLK(4000), .N_CH(3), .VAL_W(16), .DEB_MS(1), .SCAN_MS(2)) u_dut3 (
        .CLK(clk), .RST_n(rst_n), .I_KEY_CMD(1'b1), .I_SW_CMD(4'h0), .I_SW_SEL(sel3),
        .I_SW_SCAN(1'b0), .I_SW_FREEZE(1'b0), .I_VALUES(vals3), .I_ACK(1'b0), .I_ERR(1'b0),
        .O_COMM(comm3), .O_COMM_VLD(vld3), .O_PAGE(page3), .O_LEDR(ledr3));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (vld) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int nstb, bad, at;
        vals  = {19'h5_1234, 19'h0_ABCD};
        vals3 = {16'h9ABC, 16'h5678, 16'h1234};

        // Reset state
        tick(2);
        chk("rst_ledr", ledr, 0);
        chk("rst_page", page, 0);
        chk("rst_vld", vld, 0);
        chk("rst_comm", comm, 0);
        chk("rst_ledr3", ledr3, 0);
        rst_n = 1'b1;

        // Manual paging on both configurations
        for (int s = 0; s < 8; s++) begin
            sel  = s[2:0];
            sel3 = s[2:0];
            tick();
            chk("man_data", ledr[7:0], exp2[s]);
            chk("man_page", page, s);
            chk("cfg3_data", ledr3[7:0], exp6[s]);
            chk("cfg3_page", page3, s);
        end

        // Short glitch: 3 cycles low
        cmd = 4'h3;
        key = 1'b0;
        tick(3);
        key = 1'b1;
        nstb = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (vld) nstb++;
        end
        chk("glitch_nostrobe", nstb, 0);

        // Valid press: 4 cycles low, strobe on edge 6
        cmd = 4'hA;
        key = 1'b0;
        nstb = 0; bad = 0; at = -1;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) key = 1'b1;
            tick();
            if (vld) begin
                nstb++;
                if (at < 0) at = i;
                chk("press_comm", comm, 4'hA);
            end else if (comm != 4'h0) bad++;
        end
        chk("press_strobes", nstb, 1);
        chk("press_latency", at, 5);
        chk("press_comm_idle", bad, 0);

        // Sticky error and ack
        err = 1'b1; tick(); err = 1'b0;
        chk("err_set", ledr[9], 1);
        tick(5);
        chk("err_hold", ledr[9], 1);
        ack = 1'b1; tick();
        chk("ack_on", ledr[8], 1);
        ack = 1'b0; tick();
        chk("ack_off", ledr[8], 0);
        cmd = 4'h5;
        key = 1'b0;
        wait_strobe(ok);
        chk("err_strobe_seen", ok, 1);
        chk("err_comm", comm, 4'h5);
        chk("err_during_strobe", ledr[9], 1);
        tick();
        chk("err_cleared", ledr[9], 0);
        key = 1'b1; tick(12);
        err = 1'b1; tick(); err = 1'b0;
        chk("err_set2", ledr[9], 1);
        key = 1'b0;
        wait_strobe(ok);
        chk("err2_strobe_seen", ok, 1);
        err = 1'b1; tick(); err = 1'b0;
        chk("err_set_wins", ledr[9], 1);
        tick();
        chk("err_still", ledr[9], 1);
        key = 1'b1; tick(12);

        // Auto-scan 0..5,0 with 8-cycle dwell
        sel = 3'd0; tick();
        scan = 1'b1; tick();
        for (int p = 0; p < 7; p++) begin
            for (int i = 0; i < 8; i++) begin
                chk("scan_page", page, p % 6);
                chk("scan_data", ledr[7:0], exp2[p % 6]);
                tick();
            end
        end
        tick(3);
        chk("pre_frz_page", page, 1);
        // Freeze mid-dwell with 4 cycles of dwell left
        frz = 1'b1;
        ack = 1'b1;
        vals[18:0] = 19'h0_7799;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("frz_page", page, 1);
            chk("frz_data", ledr[7:0], 8'hAB);
            chk("frz_ack", ledr[8], 1);
        end
        frz = 1'b0;
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("resume_page", page, 1);
            chk("resume_data", ledr[7:0], 8'h77);
        end
        tick();
        chk("resume_adv", page, 2);
        vals[18:0] = 19'h0_ABCD;

        // Leave scan, then re-enter from an out-of-range page
        scan = 1'b0; sel = 3'd4; tick();
        chk("scan_exit", page, 4);
        sel = 3'd7; tick();
        chk("oor_page", page, 7);
        chk("oor_data", ledr[7:0], 8'h00);
        scan = 1'b1; tick();
        chk("scan_clamp", page, 0);
        tick(7);
        chk("clamp_dwell", page, 0);
        tick();
        chk("clamp_adv", page, 1);

        // Asynchronous reset during debounce and scan
        key = 1'b0;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ledr", ledr, 0);
        chk("mid_rst_page", page, 0);
        chk("mid_rst_vld", vld, 0);
        chk("mid_rst_comm", comm, 0);
        tick(2);
        rst_n = 1'b1;
        nstb = 0; at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (vld) begin
                nstb++;
                if (at < 0) at = i;
            end
        end
        chk("rst_held_strobes", nstb, 1);
        chk("rst_held_latency", at, 6);
        key = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bmp180_dbg_view.md
Name: bmp180_dbg_view

Overview:
Parametrised board-level debug viewer for the BMP180 sensor controller.
- Displays N_CH signed sensor values, 8 bits per page, plus two status LEDs.
- Turns a raw push-button into a debounced, single-cycle command pulse carrying the switch-selected command code.
- Adds auto-scan, display freeze and a sticky error indicator, none of which the earlier level-driven debug wrapper had.

Parameters:
FPGA_CLK, 50_000_000, clock frequency in Hz
N_CH, 2, number of value channels
VAL_W, 19, width of each channel value in bits; narrower values are zero-extended by the driver
DEB_MS, 10, key debounce time in ms; DEB_CYC = FPGA_CLK/1000*DEB_MS
SCAN_MS, 1000, auto-scan dwell per page in ms; SCAN_CYC = FPGA_CLK/1000*SCAN_MS
Derived: PPC = ceil(VAL_W/8) pages per channel; NPG = N_CH*PPC; SEL_W = max(1, clog2(NPG))

Ports:
CLK  in  1  system clock; single clock domain
RST_n  in  1  asynchronous active-low reset
I_KEY_CMD  in  1  raw push-button, active-low, asynchronous to CLK
I_SW_CMD  in  4  command code to issue
I_SW_SEL  in  SEL_W  manual page select
I_SW_SCAN  in  1  1 = auto-scan mode
I_SW_FREEZE  in  1  1 = hold the LED pattern
I_VALUES  in  N_CH*VAL_W  channel values; channel c is at bits [c*VAL_W +: VAL_W]
I_ACK  in  1  controller acknowledge, level
I_ERR  in  1  controller error, level
O_COMM  out  4  command code, valid only while O_COMM_VLD is high, 0 otherwise
O_COMM_VLD  out  1  one-cycle command strobe
O_PAGE  out  SEL_W  page currently displayed
O_LEDR  out  10  [9] sticky error, [8] ack, [7:0] page data

Behaviour:
Reset:
- All outputs are 0.
- Debounce state = released; all counters = 0; sticky error = 0.
- Assertion mid-operation aborts any debounce or scan count immediately.

Key path:
- 2-FF synchroniser on I_KEY_CMD.
- Debounce counter increments while the synchronised input differs from the stable state; it clears whenever the two match.
- When the counter reaches DEB_CYC-1, the stable state toggles and the counter clears.
- A released→pressed transition of the stable state causes, on the next cycle:
  - O_COMM_VLD = 1 for exactly one cycle;
  - O_COMM = I_SW_CMD sampled on the transition cycle.
- Pressed→released produces no strobe.
- A key held at reset release yields one strobe after debounce.
- Glitches shorter than DEB_CYC cycles produce no strobe.

Page selection:
- Manual mode (I_SW_SCAN = 0): page = I_SW_SEL.
  - If I_SW_SEL >= NPG, [7:0] = 0 and status bits remain live.
- Scan mode: page counter advances every SCAN_CYC cycles and wraps from NPG-1 to 0.
  - Entering scan mode starts from the current O_PAGE, clamped to 0 if out of range, with the dwell counter cleared.
  - Leaving scan mode returns to I_SW_SEL on the next cycle.
- Page p maps to channel c = p / PPC and slice k = p % PPC.
  - The channel value is zero-extended to PPC*8 bits.
  - Data = bits [(PPC-k)*8-1 -: 8], so k = 0 is the most significant byte.
  - Signed values are shown raw; no sign extension.

Status bits:
- Sticky error sets when I_ERR = 1.
- It clears on the cycle O_COMM_VLD = 1; if I_ERR is also 1 that cycle, set wins.
- O_LEDR[8] = I_ACK registered, one cycle of delay.

Output register:
- O_LEDR and O_PAGE are registered; latency from page/value change to LEDs is 1 cycle.
- While I_SW_FREEZE = 1:
  - O_LEDR[7:0] and O_PAGE hold;
  - status bits [9:8] keep updating;
  - the scan counter is paused.

Test Plan:
1. Short glitches: DEB_CYC = 4. Pulse key low for 3 cycles → no strobe. Hold low for 4 cycles with I_SW_CMD = 4'hA → O_COMM_VLD high exactly once, O_COMM = 4'hA, 0 otherwise.
2. Manual paging: N_CH = 2, VAL_W = 19, I_VALUES = {19'h5_1234, 19'h0_ABCD}. SEL = 0/1/2 → 8'h00/8'hAB/8'hCD. SEL = 3/4/5 → 8'h05/8'h12/8'h34. SEL = 6 → 8'h00.
3. Auto-scan: SCAN_CYC = 8, NPG = 6. O_PAGE sequence 0..5,0 with 8 cycles per page. Freeze for 20 cycles → page holds, then resumes the remaining dwell.
4. Sticky error: pulse I_ERR for 1 cycle → O_LEDR[9] = 1 and stays. Issue a command → clears the cycle after the strobe. Assert I_ERR in the strobe cycle → stays 1.
5. Mid-run reset: assert RST_n low during debounce and scan → all outputs 0 asynchronously. After release, a held key gives one strobe after DEB_CYC+2 cycles.
6. Reconfiguration: N_CH = 3, VAL_W = 16 (PPC = 2). Walk all 6 pages → correct byte mapping; SEL = 7 → data 0.
